// File: rtl/reg_accum_pkg.sv
// Shared types, default sizes and parameter sanity check for the block accumulator.
package reg_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_ACC_W     = 12;
    localparam int unsigned DEF_BLOCK_LEN = 4;

    // Legal configuration: sum at least as wide as a sample, at least two samples per block.
    function automatic bit widths_ok(input int unsigned data_w,
                                     input int unsigned acc_w,
                                     input int unsigned block_len);
        return (acc_w >= data_w) && (block_len >= 2);
    endfunction

endpackage

// File: rtl/reg_accum_add.sv
// Zero-extending accumulator adder; saturates and flags overflow when
// REG_ACCUM_SAT_EN is defined, wraps otherwise. Feeds registers only.
module reg_accum_add
    import reg_accum_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] data,
`ifdef REG_ACCUM_SAT_EN
    output logic              ovf_c,
`endif
    output logic [ACC_W-1:0]  sum_c
);

`ifdef REG_ACCUM_SAT_EN
    logic [ACC_W:0] full_c;

    // One extra bit catches the carry that triggers saturation.
    assign full_c = {1'b0, acc} + (ACC_W+1)'(data);
    assign ovf_c  = full_c[ACC_W];
    assign sum_c  = full_c[ACC_W] ? {ACC_W{1'b1}} : full_c[ACC_W-1:0];
`else
    assign sum_c  = acc + ACC_W'(data);
`endif

endmodule

// File: rtl/reg_accum_reader.sv
// Registered block accumulator: sums BLOCK_LEN samples and holds the sum until
// taken downstream. Optional saturation via REG_ACCUM_SAT_EN.
module reg_accum_reader
    import reg_accum_pkg::*;
#(
    parameter  int unsigned DATA_W    = DEF_DATA_W,
    parameter  int unsigned ACC_W     = DEF_ACC_W,
    parameter  int unsigned BLOCK_LEN = DEF_BLOCK_LEN,
    localparam int unsigned CNT_W     = $clog2(BLOCK_LEN)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ACC_W-1:0]  o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_A,
    output logic              o_ovf
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    state_e            state_q, state_n;
    logic [ACC_W-1:0]  acc_q, acc_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              valid_n, ready_n, a_n;
    logic [ACC_W-1:0]  data_n;
    logic [ACC_W-1:0]  sum_c;
    logic              take_c;

`ifdef REG_ACCUM_SAT_EN
    logic ovf_c;
    logic sticky_q, sticky_n;
    logic ovf_q, ovf_n;
`endif

    reg_accum_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc    (acc_q),
        .data   (i_data),
`ifdef REG_ACCUM_SAT_EN
        .ovf_c  (ovf_c),
`endif
        .sum_c  (sum_c)
    );

    assign take_c  = i_valid & o_ready;
    assign o_count = cnt_q;

    // Next-state and next-output decode; everything lands in flops below.
    always_comb begin
        state_n = state_q;
        acc_n   = acc_q;
        cnt_n   = cnt_q;
        valid_n = o_valid;
        data_n  = o_data;
        a_n     = o_A;
`ifdef REG_ACCUM_SAT_EN
        sticky_n = sticky_q;
        ovf_n    = ovf_q;
`endif
        case (state_q)
            ACCUM: begin
                if (take_c) begin
                    if (cnt_q == LAST_CNT) begin
                        data_n  = sum_c;
                        valid_n = 1'b1;
                        acc_n   = '0;
                        cnt_n   = '0;
                        state_n = HOLD;
`ifdef REG_ACCUM_SAT_EN
                        ovf_n    = sticky_q | ovf_c;
                        sticky_n = 1'b0;
`endif
                    end else begin
                        acc_n = sum_c;
                        cnt_n = cnt_q + CNT_W'(1);
`ifdef REG_ACCUM_SAT_EN
                        sticky_n = sticky_q | ovf_c;
`endif
                    end
                end
            end
            HOLD: begin
                if (i_ready) begin
                    valid_n = 1'b0;
                    a_n     = ~o_A;
                    state_n = ACCUM;
                end
            end
            default: state_n = ACCUM;
        endcase
        // Ready is a pure decode of the registered state, never of i_valid/i_ready.
        ready_n = (state_n == ACCUM);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_A     <= 1'b0;
            o_ready <= 1'b0;
`ifdef REG_ACCUM_SAT_EN
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            acc_q   <= acc_n;
            cnt_q   <= cnt_n;
            o_valid <= valid_n;
            o_data  <= data_n;
            o_A     <= a_n;
            o_ready <= ready_n;
`ifdef REG_ACCUM_SAT_EN
            sticky_q <= sticky_n;
            ovf_q    <= ovf_n;
`endif
        end
    end

`ifdef REG_ACCUM_SAT_EN
    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

    param_check: assert property (@(posedge i_clk) widths_ok(DATA_W, ACC_W, BLOCK_LEN));

endmodule

// File: doc/reg_accum_reader.md
Name: reg_accum_reader

Overview:
Loop-free, fully registered accumulator.
- Consumes a stream of DATA_W-bit samples over a valid/ready handshake.
- Sums BLOCK_LEN samples per block and presents the block sum on a valid/ready output.
- o_A is a registered toggle flag driven from a flop, not a free-running LUT loop.
- Every feedback path in the block passes through a flop; no combinational loop may exist.

Parameters:
DATA_W, 8, input sample width
ACC_W, 12, accumulator and sum width; must be >= DATA_W
BLOCK_LEN, 4, samples per block; must be >= 2
CNT_W, $clog2(BLOCK_LEN), width of sample counter (derived localparam)

Ports:
i_clk  in  1  rising-edge clock
i_rst_n  in  1  reset, asynchronous assert, active-low
i_valid  in  1  input sample valid
o_ready  out  1  block can accept a sample
i_data  in  DATA_W  input sample, unsigned
o_valid  out  1  block sum valid
i_ready  in  1  downstream accepts sum
o_data  out  ACC_W  block sum
o_count  out  CNT_W  samples accepted in current block
o_A  out  1  toggles once per completed output handshake
o_ovf  out  1  saturation flag, qualified by o_valid (tied 0 without macro)

Behaviour:
- Reset (i_rst_n=0) clears:
  - state=ACCUM, acc=0, cnt=0
  - o_valid=0, o_data=0, o_A=0, o_ovf=0
  - o_ready=0 while in reset; o_ready=1 from the first clock after release
- Reset mid-block or mid-HOLD discards the partial sum and any pending output.
- State machine ACCUM (o_ready=1):
  - Sample accepted when i_valid & o_ready.
  - Accept with cnt<BLOCK_LEN-1: acc<=acc+zext(i_data), cnt<=cnt+1.
  - Accept with cnt==BLOCK_LEN-1:
    - o_data<=acc+zext(i_data), o_valid<=1
    - acc<=0, cnt<=0
    - state->HOLD
- State machine HOLD (o_ready=0):
  - o_data and o_valid are held stable.
  - i_valid is ignored; no sample is lost because o_ready=0.
  - On i_ready: o_valid<=0, o_A<=~o_A, state->ACCUM.
- Latency: o_valid rises 1 cycle after the last sample of a block is accepted.
  - Minimum block period is BLOCK_LEN+1 cycles when i_ready is held high.
- o_ready is a registered state decode and does not depend combinationally on i_valid or i_ready.
- Arithmetic: unsigned, wraps modulo 2^ACC_W (default build).
- i_valid=0 in ACCUM: acc and cnt hold.
- o_count = cnt; it reads 0 while in HOLD.

Optional Feature:
Macro REG_ACCUM_SAT_EN.
- Defined:
  - Each add saturates at 2^ACC_W-1.
  - A sticky per-block overflow bit is set on any saturating add and is cleared when a new block starts.
  - o_ovf is loaded with the final block value together with o_data.
- Undefined: addition wraps and o_ovf is constant 0.

Decomposition:
Package reg_accum_pkg holds:
- state enum {ACCUM, HOLD}
- default DATA_W/ACC_W/BLOCK_LEN constants
- the width check function used in parameter assertions

One sub-module, reg_accum_add: combinational ACC_W adder with zero-extension. It carries the saturation/overflow output under REG_ACCUM_SAT_EN. Its output feeds only registers.

Test Plan:
- Basic sum, defaults, i_ready=1: samples 10,20,30,40 -> o_valid 1 cycle after last accept; o_data=100; o_A 0->1 after handshake.
- Wrap, ACC_W=8, macro undefined: samples 200,100,0,0 -> o_data=44, o_ovf=0.
- Saturation, ACC_W=8, REG_ACCUM_SAT_EN: samples 200,100,0,0 -> o_data=255, o_ovf=1. Next block 1,1,1,1 -> o_data=4, o_ovf=0.
- Backpressure: i_ready=0 for 5 cycles after o_valid -> o_valid and o_data stable, o_ready=0, i_valid pulses ignored. i_ready=1 -> o_valid drops the next cycle and o_ready returns.
- Input gaps: samples 5,_,_,7,_,9,11 with i_valid gaps -> o_count steps 0,1,1,1,2,2,3; o_data=32.
- Reset mid-block: accept 50,60, assert i_rst_n=0 asynchronously between edges -> outputs cleared immediately. After release, samples 1,2,3,4 -> o_data=10.
